mem_tb_pipelined: RTL
=====================

Name: mem_tb_pipelined

Overview:
- Simulation-only memory model behind the C memory DPI (mem_read8/16/32, mem_write8/16/32).
- Successor to the single-cycle 32-bit read/write-port model; used by cache and LSU benches.
- Replaces the fixed one-cycle port with one request/response channel pair using valid/ready handshakes.
- Adds byte/half/word access sizes, misalignment errors, configurable fixed latency, bounded outstanding requests and deterministic backpressure injection.

Parameters:
- LATENCY, 2: cycles from request accept to earliest response valid; legal range 1..8.
- MAX_OUTSTANDING, 4: maximum number of accepted requests whose response has not yet been consumed; legal range 1..16.
- STALL_PERIOD, 0: when nonzero, req_ready_o is forced low one cycle in every STALL_PERIOD cycles; 0 disables.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_addr_i  in  32  byte address
- req_we_i  in  1  1 = write, 0 = read
- req_size_i  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as misaligned
- req_wdata_i  in  32  write data, LSB-justified
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response ready
- resp_rdata_o  out  32  read data, zero-extended; 0 for writes and errors
- resp_err_o  out  1  misaligned or reserved-size request

Behaviour:
- Clock is clk_i. Reset is rst_i: one clock, synchronous, active-high.
- Reset values: req_ready_o=0, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0. All in-flight and queued requests are discarded. The outstanding counter and stall counter clear to 0. No DPI call is made in a reset cycle.
- req_ready_o = !rst_i && outstanding < MAX_OUTSTANDING && !stall_slot.
  - stall_slot is 1 when STALL_PERIOD != 0 and the free-running stall counter equals STALL_PERIOD-1.
  - The stall counter wraps to 0 at that value and is cleared by reset.
- Accept happens on a cycle where req_valid_i && req_ready_o at the rising edge.
- The DPI access is performed in the accept cycle, so ordering equals accept order.
  - Write: call mem_write8/16/32 with req_wdata_i[7:0]/[15:0]/[31:0]. The response carries rdata=0.
  - Read: call mem_read8/16/32 and zero-extend the result to 32 bits.
- Misaligned requests (half with addr[0]=1, word with addr[1:0]!=0, or size 3):
  - No DPI call is made.
  - The response has err=1 and rdata=0.
  - The request still counts as outstanding.
- Response timing:
  - Each accepted request enters a LATENCY-stage shift pipeline, then an in-order response FIFO of depth MAX_OUTSTANDING.
  - The earliest resp_valid_o is LATENCY cycles after the accept edge.
  - Responses always return in accept order.
- Response handshake:
  - The head response is held stable (valid, rdata, err) until resp_valid_o && resp_ready_i.
  - Consumption pops the head. The next response may be presented in the following cycle.
- Outstanding accounting:
  - outstanding increments on accept and decrements on response consume.
  - Accept and consume in the same cycle leave it unchanged.
  - outstanding never exceeds MAX_OUTSTANDING, so the pipeline plus FIFO cannot overflow.
- Back-to-back operation: with resp_ready_i held 1 and no stalls, one request per cycle is accepted and one response per cycle is returned at steady state.
- Reset asserted mid-operation discards pending responses. No response is produced for them after reset deasserts; their memory side effects already happened at accept and remain.
- Parameters outside their legal range produce a $fatal at elaboration.

Test Plan:
- Word write then read: write addr 0x100, data 0xDEADBEEF; read 0x100 -> write resp rdata=0 err=0; read resp rdata=0xDEADBEEF exactly LATENCY cycles after its accept.
- Byte/half sizing: write word 0x11223344 to 0x200; byte read 0x201 -> 0x00000033; half read 0x202 -> 0x00001122; byte write 0xAA to 0x203, then word read 0x200 -> 0xAA223344.
- Misaligned access: word read 0x302 -> err=1, rdata=0. Half write 0x301 -> err=1, and a following word read at 0x300 returns the prior contents unchanged.
- Backpressure and limit: hold resp_ready_i=0 and issue 6 reads with MAX_OUTSTANDING=4 -> exactly 4 accepted, then req_ready_o=0. Release resp_ready_i -> 4 in-order responses on consecutive cycles, then the remaining 2 are accepted.
- Stall injection with STALL_PERIOD=3 and req_valid_i held 1 -> req_ready_o low on cycles 2, 5, 8, ... after reset release; all requests complete in order.
- Reset mid-flight: accept 3 reads, assert rst_i for 1 cycle before any response -> resp_valid_o=0 afterwards, no stale responses, outstanding=0, and a new read completes normally.

Source files
------------

// File: rtl/mem_tb_pipelined.sv
// Pipelined memory model with a valid/ready request channel and an in-order response channel.
// The backing store is an internal byte array with the same access semantics as the C memory
// DPI (8/16/32-bit little-endian accesses); it is never reset, so side effects survive rst_i.
// Each accepted request performs its access at accept, travels through a LATENCY-stage shift
// pipeline and lands in a response FIFO. The outstanding limit guarantees the FIFO never overflows.
module mem_tb_pipelined #(
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STALL_PERIOD    = 0,
    parameter int unsigned MEM_AW          = 12
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $fatal(1, "mem_tb_pipelined: LATENCY must be in 1..8");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 16) begin : g_bad_outstanding
        $fatal(1, "mem_tb_pipelined: MAX_OUTSTANDING must be in 1..16");
    end
    if (MEM_AW < 2 || MEM_AW > 24) begin : g_bad_mem_aw
        $fatal(1, "mem_tb_pipelined: MEM_AW must be in 2..24");
    end

    localparam int unsigned    CntW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned    PtrW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUTSTANDING);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTSTANDING - 1);

    logic [7:0]        mem_q [2**MEM_AW];
    logic [31:0]       stall_cnt_q, stall_cnt_d;
    logic              stall_slot;
    logic [CntW-1:0]   out_q, out_d;
    logic [LATENCY-1:0] pipe_vld_q;
    logic              pipe_err_q  [LATENCY];
    logic [31:0]       pipe_data_q [LATENCY];
    logic [31:0]       fifo_data_q [MAX_OUTSTANDING];
    logic              fifo_err_q  [MAX_OUTSTANDING];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   fifo_cnt_q, fifo_cnt_d;

    logic              accept, consume, push, mem_we, misaligned;
    logic [1:0]        off;
    logic [3:0]        be;
    logic [31:0]       wlanes, rd_word, rd_sel, pipe_in_data;
    logic [MEM_AW-3:0] word_idx;
    logic              unused_addr;

    assign unused_addr = ^req_addr_i[31:MEM_AW];

    // Decode size/alignment into byte enables, write lanes and the selected read data.
    always_comb begin
        off        = req_addr_i[1:0];
        word_idx   = req_addr_i[MEM_AW-1:2];
        rd_word    = {mem_q[{word_idx, 2'd3}], mem_q[{word_idx, 2'd2}],
                      mem_q[{word_idx, 2'd1}], mem_q[{word_idx, 2'd0}]};
        misaligned = 1'b0;
        be         = 4'b0000;
        wlanes     = '0;
        rd_sel     = '0;
        case (req_size_i)
            2'd0: begin
                be     = 4'b0001 << off;
                wlanes = {4{req_wdata_i[7:0]}};
                rd_sel = {24'h0, rd_word[{off, 3'b000} +: 8]};
            end
            2'd1: begin
                misaligned = off[0];
                be         = off[1] ? 4'b1100 : 4'b0011;
                wlanes     = {2{req_wdata_i[15:0]}};
                rd_sel     = {16'h0, off[1] ? rd_word[31:16] : rd_word[15:0]};
            end
            2'd2: begin
                misaligned = |off;
                be         = 4'b1111;
                wlanes     = req_wdata_i;
                rd_sel     = rd_word;
            end
            default: misaligned = 1'b1;
        endcase
    end

    // Handshakes, stall slot and next-state for the counters and FIFO pointers.
    always_comb begin
        stall_slot   = (STALL_PERIOD != 0) && (stall_cnt_q == STALL_PERIOD - 1);
        stall_cnt_d  = (STALL_PERIOD == 0 || stall_slot) ? '0 : stall_cnt_q + 32'd1;
        req_ready_o  = !rst_i && (out_q < MaxCnt) && !stall_slot;
        resp_valid_o = (fifo_cnt_q != '0);
        resp_rdata_o = resp_valid_o ? fifo_data_q[rd_ptr_q] : '0;
        resp_err_o   = resp_valid_o && fifo_err_q[rd_ptr_q];
        accept       = req_valid_i && req_ready_o;
        consume      = resp_valid_o && resp_ready_i;
        push         = pipe_vld_q[LATENCY-1];
        mem_we       = accept && req_we_i && !misaligned;
        // Writes and errors carry zero data back.
        pipe_in_data = (req_we_i || misaligned) ? '0 : rd_sel;
        out_d        = out_q;
        if (accept && !consume) out_d = out_q + 1'b1;
        if (!accept && consume) out_d = out_q - 1'b1;
        fifo_cnt_d   = fifo_cnt_q;
        if (push && !consume) fifo_cnt_d = fifo_cnt_q + 1'b1;
        if (!push && consume) fifo_cnt_d = fifo_cnt_q - 1'b1;
        wr_ptr_d     = wr_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        rd_ptr_d     = rd_ptr_q;
        if (consume) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end

    // Control state: counters, pointers and pipeline valid bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            out_q       <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pipe_vld_q  <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            out_q         <= out_d;
            fifo_cnt_q    <= fifo_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            pipe_vld_q[0] <= accept;
            for (int i = 1; i < int'(LATENCY); i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
            end
        end
    end

    // Datapath: pipeline payload and FIFO storage; qualified by the valid bits above.
    always_ff @(posedge clk_i) begin
        pipe_err_q[0]  <= misaligned;
        pipe_data_q[0] <= pipe_in_data;
        for (int i = 1; i < int'(LATENCY); i++) begin
            pipe_err_q[i]  <= pipe_err_q[i-1];
            pipe_data_q[i] <= pipe_data_q[i-1];
        end
        if (push) begin
            fifo_err_q[wr_ptr_q]  <= pipe_err_q[LATENCY-1];
            fifo_data_q[wr_ptr_q] <= pipe_data_q[LATENCY-1];
        end
    end

    // Backing store write at accept; deliberately not reset.
    always_ff @(posedge clk_i) begin
        for (int l = 0; l < 4; l++) begin
            if (mem_we && be[l]) begin
                mem_q[{word_idx, 2'(l)}] <= wlanes[8*l +: 8];
            end
        end
    end

endmodule
